// File: rtl/regfile_pkg.sv
// Shared widths, types and helpers for the register-file write-back arbiter.
package regfile_pkg;

   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_DEPTH      = 32;
   localparam int REG_ADDR_WIDTH = $clog2(REG_DEPTH);

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t addr;
      reg_data_t data;
   } wb_req_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
      if (inc && (value != 16'hFFFF)) begin
         return value + 16'd1;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from rr_ptr upward, pointer
// moves past the winner only when a grant is actually taken.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 en,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int            IW       = $clog2(N);
   localparam logic [IW:0]   N_W      = (IW+1)'(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [IW-1:0] rr_ptr_r;
   logic [IW:0]   cand_s;
   logic          found_s;

   // First requesting index at or after rr_ptr, modulo N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      cand_s    = '0;
      for (int k = 0; k < N; k++) begin
         cand_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
         if (cand_s >= N_W) begin
            cand_s = cand_s - N_W;
         end else begin
            cand_s = cand_s;
         end
         if (en && !found_s && req[cand_s[IW-1:0]]) begin
            grant[cand_s[IW-1:0]] = 1'b1;
            grant_idx             = cand_s[IW-1:0];
            found_s               = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Pointer update: one past the winner, wrapping at N-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= '0;
      end else if (advance) begin
         rr_ptr_r <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ producers with a registered
// one-cycle write path. Optional macro REGFILE_ZERO_REG_EN suppresses writes to x0.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int DEPTH      = REG_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*$clog2(DEPTH)-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
   input  logic                                wb_stall,
   output logic                                wr_enable,
   output logic [$clog2(DEPTH)-1:0]            wr_addr,
   output logic [DATA_WIDTH-1:0]               wr_data,
   output logic [$clog2(NUM_REQ)-1:0]          grant_id,
   output logic [15:0]                         wr_count
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int IDX_WIDTH  = $clog2(NUM_REQ);

   logic                  en_s;
   logic [NUM_REQ-1:0]    grant_s;
   logic [IDX_WIDTH-1:0]  grant_idx_s;
   logic                  grant_valid_s;
   logic [ADDR_WIDTH-1:0] win_addr_s;
   logic [DATA_WIDTH-1:0] win_data_s;
   logic                  commit_s;

   logic                  wr_enable_r;
   logic [ADDR_WIDTH-1:0] wr_addr_r;
   logic [DATA_WIDTH-1:0] wr_data_r;
   logic [IDX_WIDTH-1:0]  grant_id_r;
   logic [15:0]           wr_count_r;

   // Reset also blocks grants so req_ready stays low throughout reset.
   assign en_s = ~rst & ~wb_stall;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .en        (en_s),
      .advance   (grant_valid_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   assign grant_valid_s = |grant_s;
   assign req_ready     = grant_s;

   // Winner mux: sample the granted requester's address and data this cycle.
   always_comb begin
      win_addr_s = req_addr[32'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      win_data_s = req_data[32'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
`ifdef REGFILE_ZERO_REG_EN
      commit_s   = grant_valid_s && (win_addr_s != '0);
`else
      commit_s   = grant_valid_s;
`endif
   end

   // Output register and committed-write counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_enable_r <= 1'b0;
         wr_addr_r   <= '0;
         wr_data_r   <= '0;
         grant_id_r  <= '0;
         wr_count_r  <= 16'd0;
      end else begin
         wr_enable_r <= commit_s;
         wr_count_r  <= sat_inc16(wr_count_r, commit_s);
         if (grant_valid_s) begin
            wr_addr_r  <= win_addr_s;
            wr_data_r  <= win_data_s;
            grant_id_r <= grant_idx_s;
         end else begin
            wr_addr_r  <= wr_addr_r;
            wr_data_r  <= wr_data_r;
            grant_id_r <= grant_id_r;
         end
      end
   end

   assign wr_enable = wr_enable_r;
   assign wr_addr   = wr_addr_r;
   assign wr_data   = wr_data_r;
   assign grant_id  = grant_id_r;
   assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic            wb_stall;
   logic            wr_enable;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [1:0]      grant_id;
   logic [15:0]     wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   bit           m_live = 1'b0;
   int           m_ptr;
   bit           m_en;
   int           m_addr;
   logic [31:0]  m_data;
   int           m_id;
   int           m_count;

   regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .wb_stall  (wb_stall),
      .wr_enable (wr_enable),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .grant_id  (grant_id),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int first_valid(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // Compare process: check outputs against the model, then advance the model.
   always @(negedge clk) begin
      int          w;
      logic [N-1:0] exp_ready;
      bit          commit;
      if (rst) begin
         m_live = 1'b1; m_ptr = 0; m_en = 1'b0; m_addr = 0; m_data = 32'd0; m_id = 0; m_count = 0;
         check("rst_ready", 64'(req_ready), 64'd0);
         check("rst_wr_enable", 64'(wr_enable), 64'd0);
         check("rst_wr_addr", 64'(wr_addr), 64'd0);
         check("rst_wr_data", 64'(wr_data), 64'd0);
         check("rst_grant_id", 64'(grant_id), 64'd0);
         check("rst_wr_count", 64'(wr_count), 64'd0);
      end else if (m_live) begin
         check("wr_enable", 64'(wr_enable), 64'(m_en));
         check("wr_addr", 64'(wr_addr), 64'(m_addr));
         check("wr_data", 64'(wr_data), 64'(m_data));
         check("grant_id", 64'(grant_id), 64'(m_id));
         check("wr_count", 64'(wr_count), 64'(m_count));
         w = wb_stall ? -1 : first_valid(req_valid, m_ptr);
         exp_ready = (w < 0) ? 4'b0000 : 4'(1 << w);
         check("req_ready", 64'(req_ready), 64'(exp_ready));
         if (w >= 0) begin
            m_addr = int'(req_addr[w*AW +: AW]);
            m_data = req_data[w*DW +: DW];
            m_id   = w;
            m_ptr  = (w + 1) % N;
`ifdef REGFILE_ZERO_REG_EN
            commit = (m_addr != 0);
`else
            commit = 1'b1;
`endif
            m_en = commit;
            if (commit && m_count < 65535) m_count++;
         end else begin
            m_en = 1'b0;
         end
      end
   end

   initial begin
      rst = 1'b1; wb_stall = 1'b0; req_valid = 4'b1111;
      req_addr = '0; req_data = '0;

      // reset with all requesters valid
      repeat (3) @(posedge clk);
      #2;
      check("t1_ready_in_rst", 64'(req_ready), 64'd0);
      check("t1_wr_enable_in_rst", 64'(wr_enable), 64'd0);
      check("t1_wr_count_in_rst", 64'(wr_count), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("t1_ready_after_rst", 64'(req_ready), 64'h1);

      // single requester 1
      step();
      req_valid = 4'b0010;
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      #1;
      check("t2_ready", 64'(req_ready), 64'h2);
      check("t2_prev_enable", 64'(wr_enable), 64'd1);
      check("t2_prev_id", 64'(grant_id), 64'd0);
      step();
      req_valid = 4'b0000;
      check("t2_wr_enable", 64'(wr_enable), 64'd1);
      check("t2_wr_addr", 64'(wr_addr), 64'd5);
      check("t2_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
      check("t2_grant_id", 64'(grant_id), 64'd1);

      // all valid for 8 cycles from a fresh pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         set_req(i % N, 5'(i + 1), 32'h1000 + 32'(i));
         #1 check("t3_ready", 64'(req_ready), 64'(1 << (i % N)));
         step();
         check("t3_grant_id", 64'(grant_id), 64'(i % N));
         check("t3_wr_data", 64'(wr_data), 64'h1000 + 64'(i));
         check("t3_wr_count", 64'(wr_count), 64'(i + 1));
      end

      // stall while everyone stays valid
      wb_stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1 check("t4_ready_stalled", 64'(req_ready), 64'd0);
         check("t4_wr_enable", 64'(wr_enable), (j == 0) ? 64'd1 : 64'd0);
         check("t4_wr_count", 64'(wr_count), 64'd8);
         step();
      end
      check("t4_drained", 64'(wr_enable), 64'd0);

      // same address from requesters 0 and 2
      wb_stall = 1'b0;
      req_valid = 4'b0101;
      set_req(0, 5'd7, 32'hAAAA_0001);
      set_req(2, 5'd7, 32'hBBBB_0002);
      #1 check("t5_ready0", 64'(req_ready), 64'h1);
      step();
      req_valid = 4'b0100;
      check("t5_a_addr", 64'(wr_addr), 64'd7);
      check("t5_a_data", 64'(wr_data), 64'hAAAA_0001);
      check("t5_a_id", 64'(grant_id), 64'd0);
      #1 check("t5_ready2", 64'(req_ready), 64'h4);
      step();
      req_valid = 4'b0000;
      check("t5_b_enable", 64'(wr_enable), 64'd1);
      check("t5_b_data", 64'(wr_data), 64'hBBBB_0002);
      check("t5_b_id", 64'(grant_id), 64'd2);

      // requester 3 writes register 0
      req_valid = 4'b1000;
      set_req(3, 5'd0, 32'h1234_5678);
      #1 check("t6_ready", 64'(req_ready), 64'h8);
      step();
      req_valid = 4'b0000;
`ifdef REGFILE_ZERO_REG_EN
      check("t6_x0_enable", 64'(wr_enable), 64'd0);
      check("t6_x0_count", 64'(wr_count), 64'd10);
`else
      check("t6_x0_enable", 64'(wr_enable), 64'd1);
      check("t6_x0_addr", 64'(wr_addr), 64'd0);
      check("t6_x0_count", 64'(wr_count), 64'd11);
`endif

      // randomized traffic with occasional stalls and resets
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         wb_stall  = ($urandom_range(0, 4) == 0);
         req_valid = 4'($urandom);
         for (int i = 0; i < N; i++) set_req(i, 5'($urandom), $urandom);
         step();
      end

      rst = 1'b0; wb_stall = 1'b0; req_valid = 4'b0000;
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
